// File: rtl/ccr_branch_unit.sv
// Condition code register and conditional-branch sequencer.
// Captures the ALU's NZVC flags into the CCR and resolves conditional branches
// against them. A taken branch fetches its target operand and loads the PC. A
// not-taken branch skips the operand byte.
// Optional build macro CCR_FWD_EN: when CCR_Load and Br_Start coincide in IDLE,
// the condition is evaluated on NZVC_In instead of the registered CCR.
module ccr_branch_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] NZVC_In,
  input  logic       CCR_Load,
  input  logic       Br_Start,
  input  logic [2:0] Br_Cond,
  input  logic [7:0] Target_In,
  input  logic       Target_Valid,
  output logic [3:0] CCR_Out,
  output logic       Target_Req,
  output logic [7:0] Target_Out,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       Br_Done,
  output logic       Br_Taken,
  output logic       Br_Err
);

  // The counter needs at least one bit, even when the timeout is disabled.
  localparam int CntW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam logic [CntW-1:0] CntMax = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StLoad = 3'd2,
    StSkip = 3'd3,
    StDone = 3'd4,
    StErr  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      ccr_q, ccr_d;
  logic [7:0]      target_q, target_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            taken_q, taken_d;
  logic [3:0]      eval_flags;

  // Returns 1 when the flags satisfy condition code c.
  function automatic logic cond_met(input logic [2:0] c, input logic [3:0] f);
    logic r;
    case (c)
      3'b000:  r = 1'b1;
      3'b001:  r = f[3];
      3'b010:  r = ~f[3];
      3'b011:  r = f[2];
      3'b100:  r = ~f[2];
      3'b101:  r = f[1];
      3'b110:  r = ~f[1];
      default: r = f[0];
    endcase
    return r;
  endfunction

  // Select the flags that the branch condition is tested against.
`ifdef CCR_FWD_EN
  always_comb begin
    eval_flags = ccr_q;
    if (CCR_Load) eval_flags = NZVC_In;
  end
`else
  always_comb begin
    eval_flags = ccr_q;
  end
`endif

  // Next-state logic for the CCR, the FSM, the target register and the timeout counter.
  always_comb begin
    state_d  = state_q;
    ccr_d    = ccr_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    taken_d  = taken_q;

    if (CCR_Load) ccr_d = NZVC_In;

    case (state_q)
      StIdle: begin
        if (Br_Start) begin
          taken_d = cond_met(Br_Cond, eval_flags);
          cnt_d   = '0;
          state_d = taken_d ? StReq : StSkip;
        end
      end
      StReq: begin
        if (Target_Valid) begin
          target_d = Target_In;
          state_d  = StLoad;
        end else if ((TIMEOUT > 0) && (cnt_q == CntMax)) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLoad:  state_d = StDone;
      StSkip:  state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      ccr_q    <= 4'b0000;
      target_q <= 8'h00;
      cnt_q    <= '0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ccr_q    <= ccr_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      taken_q  <= taken_d;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    CCR_Out    = ccr_q;
    Target_Out = target_q;
    Target_Req = (state_q == StReq);
    PC_Load    = (state_q == StLoad);
    PC_Inc     = (state_q == StSkip);
    Br_Done    = (state_q == StDone) || (state_q == StErr);
    Br_Taken   = (state_q == StDone) && taken_q;
    Br_Err     = (state_q == StErr);
  end

endmodule
